// File: rtl/countdown_timer_pkg.sv
// Shared types and constants for the countdown timer.
// Holds the timer state encoding and the default count width.
package countdown_timer_pkg;

   localparam int DEFAULT_WIDTH = 32;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

endpackage

// File: rtl/ripple_subtractor.sv
// WIDTH-bit ripple-carry decrementer: o_diff = i_a - 1.
// Ports: i_a (operand), o_diff (operand minus one, carry-out dropped).
module ripple_subtractor #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] i_a,
   output logic [WIDTH-1:0] o_diff
);

   // Minus one is realised as i_a plus all-ones with carry-in zero.
   logic [WIDTH:0] w_carry;

   assign w_carry[0] = 1'b0;

   for (genvar g = 0; g < WIDTH; g++) begin : g_fa
      assign o_diff[g]    = i_a[g] ^ 1'b1 ^ w_carry[g];
      assign w_carry[g+1] = i_a[g] | w_carry[g];
   end

endmodule

// File: rtl/countdown_timer.sv
// Loadable down-counter with valid/ready load and a one-cycle done pulse.
// Ports: i_clk, i_rst (sync, active-high), i_load_valid/o_load_ready,
//   i_load_value, i_enable, i_cancel, o_count, o_busy, o_done.
// Build option COUNTDOWN_AUTORELOAD_EN: reload N at terminal count.
module countdown_timer
   import countdown_timer_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_load_valid,
   output logic             o_load_ready,
   input  logic [WIDTH-1:0] i_load_value,
   input  logic             i_enable,
   input  logic             i_cancel,
   output logic [WIDTH-1:0] o_count,
   output logic             o_busy,
   output logic             o_done
);

   localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

   state_t           r_state;
   logic [WIDTH-1:0] r_count;
   logic             r_done;
   logic             r_busy;
   logic             r_ready;
   logic [WIDTH-1:0] w_dec;
   logic             w_last;
`ifdef COUNTDOWN_AUTORELOAD_EN
   logic [WIDTH-1:0] r_reload;
`endif

   ripple_subtractor #(
      .WIDTH (WIDTH)
   ) u_sub (
      .i_a    (r_count),
      .o_diff (w_dec)
   );

   assign w_last = (r_count == ONE);

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= IDLE;
         r_count <= '0;
         r_done  <= 1'b0;
         r_busy  <= 1'b0;
         r_ready <= 1'b1;
`ifdef COUNTDOWN_AUTORELOAD_EN
         r_reload <= '0;
`endif
      end else begin
         r_done <= 1'b0;
         unique case (r_state)
            IDLE: begin
               if (i_load_valid) begin
                  r_count <= i_load_value;
`ifdef COUNTDOWN_AUTORELOAD_EN
                  r_reload <= i_load_value;
`endif
                  if (i_load_value == '0) begin
                     r_done <= 1'b1;
                  end else begin
                     r_state <= RUN;
                     r_busy  <= 1'b1;
                     r_ready <= 1'b0;
                  end
               end
            end
            RUN: begin
               if (i_cancel) begin
                  r_state <= IDLE;
                  r_busy  <= 1'b0;
                  r_ready <= 1'b1;
               end else if (i_enable) begin
                  if (w_last) begin
                     r_done <= 1'b1;
`ifdef COUNTDOWN_AUTORELOAD_EN
                     r_count <= r_reload;
`else
                     r_count <= '0;
                     r_state <= IDLE;
                     r_busy  <= 1'b0;
                     r_ready <= 1'b1;
`endif
                  end else begin
                     r_count <= w_dec;
                  end
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign o_count      = r_count;
   assign o_done       = r_done;
   assign o_busy       = r_busy;
   assign o_load_ready = r_ready;

endmodule
